axi_rd_slave_engine: RTL and testbench

AXI_RD_SLAVE_ENGINE -- requirements
Module: axi_rd_slave_engine

---
 rtl/axi_rd_slave_engine_if.sv | 42 ++++
 rtl/axi_rd_slave_engine.sv | 162 ++++++++++++++++
 tb/tb_axi_rd_slave_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_slave_engine_if.sv
// AXI4 read-channel (AR/R) bundle plus the backing-memory read port.
// "slave" is the engine's view; "master" is the view of whatever drives AR and sinks R.
interface axi_rd_slave_engine_if #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  logic [IDW-1:0] s_axi_arid;
  logic [AW-1:0]  s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [2:0]     s_axi_arsize;
  logic [1:0]     s_axi_arburst;
  logic           s_axi_arvalid;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_rd_addr;
  logic [DW-1:0]  mem_rd_data;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data
  );
endinterface

// File: rtl/axi_rd_slave_engine.sv
// AXI4 read slave: queues AR commands and plays each out as R beats from a 1-cycle-latency memory.
// Handshakes: a transfer happens on a clock edge where valid && ready; valid never waits on ready and
// R payload holds while rvalid && !rready. dbg_burst is 1 while the engine is in its BURST state.
module axi_rd_slave_engine #(
  parameter int IDW   = 12,
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_rd_slave_engine_if.slave bus,
  output logic                 dbg_burst
);
  localparam int PW         = $clog2(DEPTH);
  localparam int LOG2_BYTES = $clog2(DW / 8);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic           err;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  cmd_t           fifo_mem [DEPTH];
  cmd_t           cmd_in;
  cmd_t           head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count, count_next;
  logic           arready_q;
  logic           push, pop, wrap_len_ok;

  state_t         state;
  logic [IDW-1:0] b_id;
  logic [7:0]     b_len;
  logic [2:0]     b_size;
  logic [1:0]     b_burst;
  logic           b_err;
  logic [AW-1:0]  cur_addr, next_addr, s_bytes, wrap_mask;
  logic [7:0]     beat_cnt;
  logic           issued_all;
  logic           issue, r_hs;

  logic           rvalid_q, rlast_q, rerr_q;
  logic [IDW-1:0] rid_q;
  logic [1:0]     rresp_q;

  assign wrap_len_ok = (bus.s_axi_arlen == 8'd1) || (bus.s_axi_arlen == 8'd3) ||
                       (bus.s_axi_arlen == 8'd7) || (bus.s_axi_arlen == 8'd15);

  assign cmd_in.id    = bus.s_axi_arid;
  assign cmd_in.addr  = bus.s_axi_araddr;
  assign cmd_in.len   = bus.s_axi_arlen;
  assign cmd_in.size  = bus.s_axi_arsize;
  assign cmd_in.burst = bus.s_axi_arburst;
  assign cmd_in.err   = (bus.s_axi_arburst == 2'b11) ||
                        (bus.s_axi_arsize > 3'(LOG2_BYTES)) ||
                        ((bus.s_axi_arburst == 2'b10) && !wrap_len_ok);

  assign push       = bus.s_axi_arvalid && arready_q;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = fifo_mem[rd_ptr];
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // arready is registered from the next-cycle fill level, so it is low in reset and never lets a push hit a full queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      arready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      arready_q <= (count_next != (PW+1)'(DEPTH));
    end
  end

  assign issue = (state == BURST) && !issued_all && (!rvalid_q || bus.s_axi_rready);
  assign r_hs  = rvalid_q && bus.s_axi_rready;

  // WRAP keeps the bits above the container and wraps only the offset bits.
  always_comb begin
    s_bytes   = AW'(1) << b_size;
    wrap_mask = ((AW'(b_len) + AW'(1)) << b_size) - AW'(1);
    next_addr = cur_addr;
    case (b_burst)
      2'b00:   next_addr = cur_addr;
      2'b10:   next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + s_bytes) & wrap_mask);
      default: next_addr = (cur_addr & ~(s_bytes - AW'(1))) + s_bytes;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      b_id       <= '0;
      b_len      <= '0;
      b_size     <= '0;
      b_burst    <= '0;
      b_err      <= 1'b0;
      cur_addr   <= '0;
      beat_cnt   <= '0;
      issued_all <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rerr_q     <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            b_id       <= head.id;
            b_len      <= head.len;
            b_size     <= head.size;
            b_burst    <= head.burst;
            b_err      <= head.err;
            cur_addr   <= head.addr;
            beat_cnt   <= '0;
            issued_all <= 1'b0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            rid_q    <= b_id;
            rresp_q  <= b_err ? 2'b10 : 2'b00;
            rerr_q   <= b_err;
            rlast_q  <= (beat_cnt == b_len);
            cur_addr <= next_addr;
            if (beat_cnt == b_len) issued_all <= 1'b1;
            else                   beat_cnt   <= beat_cnt + 8'd1;
          end
          if (r_hs && rlast_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue)     rvalid_q <= 1'b1;
      else if (r_hs) rvalid_q <= 1'b0;
    end
  end

  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rlast   = rlast_q;
  assign bus.s_axi_rid     = rid_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rerr_q ? '0 : bus.mem_rd_data;
  assign bus.mem_rd_en     = issue && !b_err;
  assign bus.mem_rd_addr   = cur_addr;
  assign dbg_burst         = (state == BURST);
endmodule

// File: tb/tb_axi_rd_slave_engine.sv
// Bench for axi_rd_slave_engine: AR driver, 1-cycle memory model, R/memory-address scoreboard
// fed by an independent burst-address model, and per-scenario tasks.
module tb_axi_rd_slave_engine;
  localparam int IDW   = 12;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int EW    = IDW + 2 + 1 + DW;

  logic clk = 1'b0;
  logic rst;
  logic dbg_burst;

  always #5 clk = ~clk;

  axi_rd_slave_engine_if #(.IDW(IDW), .AW(AW), .DW(DW)) bus ();

  axi_rd_slave_engine #(.IDW(IDW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_burst (dbg_burst)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int mem_en_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] obs_addr_q[$];
  logic [EW-1:0] mon_e, mon_o;
  logic [AW-1:0] mon_ea;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [31:0] lo;
    lo = a * 32'h9E37_79B9;
    return {a ^ 32'hDEAD_BEEF, lo};
  endfunction

  // Backing memory: data appears the cycle after mem_rd_en and holds until the next read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= data_of(bus.mem_rd_addr);
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.mem_rd_en) begin
        mem_en_cnt++;
        obs_addr_q.push_back(bus.mem_rd_addr);
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL mem_addr: got unexpected read at %h, expected no read", bus.mem_rd_addr);
        end else begin
          mon_ea = exp_addr_q.pop_front();
          if (bus.mem_rd_addr !== mon_ea) begin
            n_bad++;
            $display("FAIL mem_addr: got %h expected %h", bus.mem_rd_addr, mon_ea);
          end
        end
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        hs_cnt++;
        n_cmp++;
        mon_o = {bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rlast, bus.s_axi_rdata};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL r_beat: got unexpected beat %h, expected none", mon_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_o !== mon_e) begin
            n_bad++;
            $display("FAIL r_beat: got id/resp/last/data %h expected %h", mon_o, mon_e);
          end
        end
      end
    end
  end

  task automatic model_push(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic          err;
    logic [AW-1:0] s_b, l_b, base, a, ba;
    err  = (burst == 2'b11) || (size > 3'd3) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    s_b  = 32'd1 << size;
    l_b  = (AW'(len) + 32'd1) * s_b;
    base = (addr / l_b) * l_b;
    a    = addr;
    for (int n = 0; n <= int'(len); n++) begin
      case (burst)
        2'b01:   ba = (n == 0) ? addr : ((addr / s_b) * s_b + AW'(n) * s_b);
        2'b10: begin
          ba = a;
          a  = base + ((a + s_b - base) % l_b);
        end
        default: ba = addr;
      endcase
      if (!err) exp_addr_q.push_back(ba);
      exp_q.push_back({id, err ? 2'b10 : 2'b00, (n == int'(len)), err ? {DW{1'b0}} : data_of(ba)});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic acc;
    bit   ok;
    ok = 1'b0;
    bus.s_axi_arid    = id;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arsize  = size;
    bus.s_axi_arburst = burst;
    bus.s_axi_arvalid = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      acc = bus.s_axi_arready;
      @(posedge clk);
      if (acc) ok = 1'b1;
    end
    #1;
    bus.s_axi_arvalid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ar_accept: got no arready for id %h, expected acceptance", id);
    end else begin
      model_push(id, addr, len, size, burst);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain: got %0d beats left, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b expected 0", bus.s_axi_rvalid); end
    n_cmp++; if (bus.s_axi_rlast !== 1'b0) begin n_bad++; $display("FAIL rst_rlast: got %b expected 0", bus.s_axi_rlast); end
    n_cmp++; if (bus.s_axi_rresp !== 2'b00) begin n_bad++; $display("FAIL rst_rresp: got %b expected 00", bus.s_axi_rresp); end
    n_cmp++; if (bus.s_axi_rid !== '0) begin n_bad++; $display("FAIL rst_rid: got %h expected 0", bus.s_axi_rid); end
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b expected 0", bus.mem_rd_en); end
    n_cmp++; if (bus.mem_rd_addr !== '0) begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_rd_addr); end
    n_cmp++; if (bus.s_axi_arready !== 1'b0) begin n_bad++; $display("FAIL rst_arready: got %b expected 0", bus.s_axi_arready); end
    n_cmp++; if (dbg_burst !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %b expected 0 (IDLE)", dbg_burst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.s_axi_arready !== 1'b1) begin n_bad++; $display("FAIL post_rst_arready: got %b expected 1", bus.s_axi_arready); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    logic [AW-1:0] want [4];
    int h0;
    want = '{32'h1004, 32'h1008, 32'h1010, 32'h1018};
    obs_addr_q.delete();
    h0 = hs_cnt;
    bus.s_axi_rready = 1'b1;
    send_ar(12'h005, 32'h1004, 8'd3, 3'd3, 2'b01);
    drain();
    n_cmp++;
    if (hs_cnt - h0 != 4) begin n_bad++; $display("FAIL incr_beats: got %0d expected 4", hs_cnt - h0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_addr_q.size()) begin n_bad++; $display("FAIL incr_addr%0d: got none expected %h", i, want[i]); end
      else if (obs_addr_q[i] !== want[i]) begin n_bad++; $display("FAIL incr_addr%0d: got %h expected %h", i, obs_addr_q[i], want[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    want = '{32'h38, 32'h20, 32'h28, 32'h30};
    obs_addr_q.delete();
    bus.s_axi_rready = 1'b1;
    send_ar(12'h006, 32'h38, 8'd3, 3'd3, 2'b10);
    drain();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_addr_q.size()) begin n_bad++; $display("FAIL wrap_addr%0d: got none expected %h", i, want[i]); end
      else if (obs_addr_q[i] !== want[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h expected %h", i, obs_addr_q[i], want[i]); end
    end
  endtask

  task automatic test_long();
    int h0;
    h0 = hs_cnt;
    bus.s_axi_rready = 1'b1;
    send_ar(12'h0FF, 32'hFFFF_FF00, 8'd255, 3'd3, 2'b01);
    drain();
    n_cmp++;
    if (hs_cnt - h0 != 256) begin n_bad++; $display("FAIL long_beats: got %0d expected 256", hs_cnt - h0); end
  endtask

  task automatic test_fill();
    bus.s_axi_rready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      send_ar(IDW'(12'h100 + i), AW'(32'h2000 + i * 64), 8'(i % 3), 3'd3, 2'b01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.s_axi_arready !== 1'b0) begin n_bad++; $display("FAIL fill_arready: got %b expected 0", bus.s_axi_arready); end
    @(posedge clk); #1;
    bus.s_axi_rready = 1'b1;
    drain();
  endtask

  task automatic test_backpressure();
    logic          p_stall;
    logic [EW-1:0] p_val, c_val;
    bit            done;
    done = 1'b0;
    p_stall = 1'b0;
    p_val = '0;
    bus.s_axi_rready = 1'b0;
    send_ar(12'h0AB, 32'h3000, 8'd5, 3'd3, 2'b01);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      c_val = {bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rlast, bus.s_axi_rdata};
      if (p_stall) begin
        n_cmp++;
        if (bus.s_axi_rvalid !== 1'b1 || c_val !== p_val) begin
          n_bad++;
          $display("FAIL bp_hold: got valid %b payload %h expected valid 1 payload %h", bus.s_axi_rvalid, c_val, p_val);
        end
      end
      if (bus.mem_rd_en) begin
        n_cmp++;
        if (bus.s_axi_rvalid && !bus.s_axi_rready) begin
          n_bad++;
          $display("FAIL bp_mem_en: got read while R slot stalled, expected none");
        end
      end
      p_stall = bus.s_axi_rvalid && !bus.s_axi_rready;
      p_val   = c_val;
      if (exp_q.size() == 0) done = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_rready = ~bus.s_axi_rready;
    end
    bus.s_axi_rready = 1'b1;
    drain();
  endtask

  task automatic test_errors();
    int m0, h0;
    m0 = mem_en_cnt;
    h0 = hs_cnt;
    bus.s_axi_rready = 1'b1;
    send_ar(12'h0E1, 32'h100, 8'd1, 3'd3, 2'b11);
    send_ar(12'h0E2, 32'h200, 8'd2, 3'd3, 2'b10);
    send_ar(12'h0E3, 32'h300, 8'd0, 3'd4, 2'b01);
    drain();
    n_cmp++;
    if (mem_en_cnt != m0) begin n_bad++; $display("FAIL err_mem_en: got %0d reads expected 0", mem_en_cnt - m0); end
    n_cmp++;
    if (hs_cnt - h0 != 6) begin n_bad++; $display("FAIL err_beats: got %0d expected 6", hs_cnt - h0); end
  endtask

  task automatic test_random();
    bit stop;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [1:0] br;
          logic [7:0] ln;
          br = 2'($urandom_range(0, 2));
          ln = (br == 2'b10) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 9));
          send_ar(IDW'($urandom_range(0, 4095)), AW'($urandom), ln, 3'($urandom_range(0, 3)), br);
        end
        drain();
        stop = 1'b1;
      end
      begin
        for (int k = 0; k < 20000 && !stop; k++) begin
          @(posedge clk); #1;
          bus.s_axi_rready = ($urandom_range(0, 3) != 0);
        end
        bus.s_axi_rready = 1'b1;
      end
    join
    bus.s_axi_rready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int h0, seen;
    bit hit;
    hit = 1'b0;
    seen = 0;
    bus.s_axi_rready = 1'b1;
    send_ar(12'h077, 32'h4000, 8'd7, 3'd3, 2'b01);
    h0 = hs_cnt;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk); #1;
      if (hs_cnt - h0 >= 1) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL rmid_start: got no first beat, expected one"); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.s_axi_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_rvalid: got %b expected 0", bus.s_axi_rvalid); end
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.s_axi_rvalid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rmid_no_beats: got %0d valid cycles expected 0", seen); end
    n_cmp++;
    if (bus.s_axi_arready !== 1'b1) begin n_bad++; $display("FAIL rmid_arready: got %b expected 1", bus.s_axi_arready); end
    @(posedge clk); #1;
    send_ar(12'h078, 32'h5008, 8'd2, 3'd2, 2'b01);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_arid    = '0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arlen   = '0;
    bus.s_axi_arsize  = '0;
    bus.s_axi_arburst = '0;
    bus.s_axi_rready  = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_incr();
    test_wrap();
    test_long();
    test_fill();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
